xgmii_tx_framer: RTL and testbench

//  Converts a 32-bit byte-stream frame interface into a continuous 32-bit XGMII TX word stream.

---
 rtl/xgmii_tx_framer.sv | 166 ++++++++++++++++
 tb/tb_xgmii_tx_framer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_tx_framer.sv
// xgmii_tx_framer: frames a 32-bit byte stream into a continuous XGMII TX word stream
//   Adds the preamble/SFD, appends the CRC32 FCS and /T/, then sends IPG_WORDS idle words.
//   clk            in   clock, all logic on posedge
//   rst            in   synchronous active-low reset
//   i_s_data       in   frame bytes, byte0 in [7:0]
//   i_s_keep       in   valid lanes (0001/0011/0111/1111 on last word, else 1111)
//   i_s_valid      in   source word valid
//   i_s_last       in   final word of frame
//   o_s_ready      out  word accepted when valid && ready (combinational from i_xgmii_rdy)
//   o_xgmii_data   out  XGMII TX data, lane0 = [7:0]
//   o_xgmii_ctrl   out  XGMII TX control, bit i = lane i
//   o_xgmii_ena    out  output word valid
//   i_xgmii_rdy    in   downstream takes the current word; 0 holds everything
//   o_underrun_err out  1-cycle pulse when a frame is aborted by a source underrun
//   o_frame_cnt    out  frames completed with /T/ (wraps)
module xgmii_tx_framer #(
    parameter int IPG_WORDS = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          i_s_data,
    input  logic [3:0]           i_s_keep,
    input  logic                 i_s_valid,
    input  logic                 i_s_last,
    output logic                 o_s_ready,
    output logic [31:0]          o_xgmii_data,
    output logic [3:0]           o_xgmii_ctrl,
    output logic                 o_xgmii_ena,
    input  logic                 i_xgmii_rdy,
    output logic                 o_underrun_err,
    output logic [CNT_WIDTH-1:0] o_frame_cnt
);
    localparam logic [2:0] IDLE = 3'd0, PRE = 3'd1, DATA = 3'd2, FCSW = 3'd3,
                           TAIL = 3'd4, DROP = 3'd5, IPG = 3'd6;
    localparam logic [31:0] IDLE_W = 32'h07070707, START_W = 32'h555555FB,
                            SFD_W = 32'hD5555555, ERR_W = 32'hFEFEFEFE;
    localparam int IW = $clog2(IPG_WORDS) + 1;

    logic [2:0]           r_state;
    logic [31:0]          r_data, r_crc, r_fcs;
    logic [3:0]           r_ctrl;
    logic                 r_ena, r_err;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [IW-1:0]        r_ipg;
    logic [1:0]           r_rem;
    logic [31:0]          w_crc, w_fcs, w_mask, w_last_word, w_tail_fcs, w_tail_d;
    logic [3:0]           w_tail_c;
    logic [2:0]           w_k;

    function automatic logic [31:0] f_crc(input logic [31:0] c, input logic [31:0] d, input logic [3:0] k);
        logic [31:0] x;
        x = c;
        for (int b = 0; b < 4; b++) begin
            if (k[b]) begin
                x = x ^ {24'h0, d[8*b +: 8]};
                for (int j = 0; j < 8; j++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
            end
        end
        return x;
    endfunction

    assign w_crc = f_crc(r_crc, i_s_data, i_s_keep);
    assign w_fcs = ~w_crc;
    assign w_k = {2'b0, i_s_keep[0]} + {2'b0, i_s_keep[1]} + {2'b0, i_s_keep[2]} + {2'b0, i_s_keep[3]};
    // last word: data in the kept lanes, the leading FCS bytes fill the rest
    assign w_last_word = (i_s_data & w_mask) | ((w_fcs << {w_k, 3'b0}) & ~w_mask);
    // the first 4-r FCS bytes already went out, so the remaining r start at byte 4-r
    assign w_tail_fcs = r_fcs >> {3'd4 - {1'b0, r_rem}, 3'b0};

    always_comb begin
        w_mask = '0;
        w_tail_d = '0;
        w_tail_c = '0;
        for (int i = 0; i < 4; i++) begin
            w_mask[8*i +: 8] = {8{i_s_keep[i]}};
            w_tail_d[8*i +: 8] = (i < int'(r_rem)) ? w_tail_fcs[8*i +: 8] : (i == int'(r_rem)) ? 8'hFD : 8'h07;
            w_tail_c[i] = (i >= int'(r_rem));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IPG;
            r_ipg   <= IW'(IPG_WORDS - 1);
            r_data  <= IDLE_W;
            r_ctrl  <= 4'hF;
            r_ena   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_crc   <= '1;
            r_fcs   <= '0;
            r_rem   <= '0;
        end else begin
            r_ena <= 1'b1;
            r_err <= i_xgmii_rdy && r_state == DATA && !i_s_valid;
            if (i_xgmii_rdy) begin
                case (r_state)
                    IDLE: begin
                        r_data <= i_s_valid ? START_W : IDLE_W;
                        r_ctrl <= i_s_valid ? 4'h1 : 4'hF;
                        if (i_s_valid) r_state <= PRE;
                    end
                    PRE: begin
                        r_data  <= SFD_W;
                        r_ctrl  <= 4'h0;
                        r_crc   <= '1;
                        r_state <= DATA;
                    end
                    DATA: begin
                        if (!i_s_valid) begin
                            r_data  <= ERR_W;
                            r_ctrl  <= 4'hF;
                            r_state <= DROP;
                        end else if (!i_s_last) begin
                            r_data <= i_s_data;
                            r_ctrl <= 4'h0;
                            r_crc  <= w_crc;
                        end else begin
                            // k=4 leaves no room for FCS: a whole FCS word follows with r=0
                            r_data  <= w_last_word;
                            r_ctrl  <= 4'h0;
                            r_fcs   <= w_fcs;
                            r_rem   <= w_k[1:0];
                            r_state <= (w_k == 3'd4) ? FCSW : TAIL;
                        end
                    end
                    FCSW: begin
                        r_data  <= r_fcs;
                        r_ctrl  <= 4'h0;
                        r_state <= TAIL;
                    end
                    TAIL: begin
                        r_data  <= w_tail_d;
                        r_ctrl  <= w_tail_c;
                        r_cnt   <= r_cnt + 1'b1;
                        r_ipg   <= IW'(IPG_WORDS - 1);
                        r_state <= IPG;
                    end
                    DROP: begin
                        r_data <= IDLE_W;
                        r_ctrl <= 4'hF;
                        if (i_s_valid && i_s_last) begin
                            r_ipg   <= IW'(IPG_WORDS - 1);
                            r_state <= IPG;
                        end
                    end
                    IPG: begin
                        r_data  <= IDLE_W;
                        r_ctrl  <= 4'hF;
                        r_ipg   <= r_ipg - 1'b1;
                        if (r_ipg == '0) r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_s_ready      = i_xgmii_rdy && (r_state == DATA || r_state == DROP);
    assign o_xgmii_data   = r_data;
    assign o_xgmii_ctrl   = r_ctrl;
    assign o_xgmii_ena    = r_ena;
    assign o_underrun_err = r_err;
    assign o_frame_cnt    = r_cnt;
endmodule

// File: tb/tb_xgmii_tx_framer.sv
// tb_xgmii_tx_framer: self-checking bench for xgmii_tx_framer
module tb_xgmii_tx_framer;
    localparam int IPG = 3;
    localparam int CW = 4;

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [31:0] d; logic [3:0] c; } xw_t;
    typedef struct { logic [31:0] d; logic [3:0] k; logic l; } sw_t;
    typedef struct {
        logic v; logic [31:0] d; logic [3:0] k; logic l;
        logic rdy; logic [31:0] xd; logic [3:0] xc; logic [CW-1:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] i_s_data;
    logic [3:0] i_s_keep;
    logic i_s_valid, i_s_last, o_s_ready;
    logic [31:0] o_xgmii_data;
    logic [3:0] o_xgmii_ctrl;
    logic o_xgmii_ena, i_xgmii_rdy, o_underrun_err;
    logic [CW-1:0] o_frame_cnt;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;
    xw_t exp_q[$];
    sw_t src_q[$];
    logic [31:0] p_data;
    logic [3:0] p_ctrl;
    vec_t tv[12];

    xgmii_tx_framer #(.IPG_WORDS(IPG), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .i_s_data(i_s_data), .i_s_keep(i_s_keep), .i_s_valid(i_s_valid), .i_s_last(i_s_last),
        .o_s_ready(o_s_ready),
        .o_xgmii_data(o_xgmii_data), .o_xgmii_ctrl(o_xgmii_ctrl), .o_xgmii_ena(o_xgmii_ena),
        .i_xgmii_rdy(i_xgmii_rdy), .o_underrun_err(o_underrun_err), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick(output logic acc, output logic rs);
        @(negedge clk);
        acc = i_s_valid && o_s_ready;
        rs = o_s_ready;
        p_data = o_xgmii_data;
        p_ctrl = o_xgmii_ctrl;
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input logic v, input logic [31:0] d, input logic [3:0] k, input logic l);
        i_s_valid = v;
        i_s_data = d;
        i_s_keep = k;
        i_s_last = l;
    endtask

    task automatic idle_words(input int n);
        xw_t x;
        x.d = 32'h07070707;
        x.c = 4'hF;
        repeat (n) exp_q.push_back(x);
    endtask

    // Reference: the frame as a byte/ctrl stream on the wire, cut into 4-byte words.
    task automatic add_frame(input bq_t b);
        logic [31:0] crc;
        logic [8:0] s[$];
        sw_t w;
        xw_t x;
        crc = '1;
        foreach (b[i]) begin
            crc = crc ^ {24'h0, b[i]};
            for (int j = 0; j < 8; j++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        for (int i = 0; i < b.size(); i += 4) begin
            w.d = '0;
            w.k = '0;
            for (int j = 0; j < 4; j++) if (i + j < b.size()) begin
                w.d[8*j +: 8] = b[i+j];
                w.k[j] = 1'b1;
            end
            w.l = (i + 4 >= b.size());
            src_q.push_back(w);
        end
        s.push_back({1'b1, 8'hFB});
        repeat (6) s.push_back({1'b0, 8'h55});
        s.push_back({1'b0, 8'hD5});
        foreach (b[i]) s.push_back({1'b0, b[i]});
        crc = ~crc;
        for (int j = 0; j < 4; j++) s.push_back({1'b0, crc[8*j +: 8]});
        s.push_back({1'b1, 8'hFD});
        while (s.size() % 4 != 0) s.push_back({1'b1, 8'h07});
        for (int i = 0; i < s.size(); i += 4) begin
            for (int j = 0; j < 4; j++) begin
                x.d[8*j +: 8] = s[i+j][7:0];
                x.c[j] = s[i+j][8];
            end
            exp_q.push_back(x);
        end
        idle_words(IPG);
        exp_cnt++;
    endtask

    task automatic rand_frame();
        bq_t q;
        int n;
        n = $urandom_range(1, 24);
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        add_frame(q);
    endtask

    task automatic add_t1();
        bq_t q;
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        add_frame(q);
    endtask

    task automatic run(input bit rnd);
        int n;
        logic acc, rs;
        xw_t e;
        n = 0;
        while (exp_q.size() > 0 && n < 20000) begin
            n++;
            i_xgmii_rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (src_q.size() > 0) set_src(1'b1, src_q[0].d, src_q[0].k, src_q[0].l);
            else set_src(1'b0, '0, '0, 1'b0);
            tick(acc, rs);
            if (acc) void'(src_q.pop_front());
            if (i_xgmii_rdy) begin
                e = exp_q.pop_front();
                chk("run_data", o_xgmii_data, e.d);
                chk("run_ctrl", {28'h0, o_xgmii_ctrl}, {28'h0, e.c});
            end else begin
                chk("hold_data", o_xgmii_data, p_data);
                chk("hold_ctrl", {28'h0, o_xgmii_ctrl}, {28'h0, p_ctrl});
                chk("hold_ready", {31'h0, rs}, 32'h0);
            end
            chk("run_ena", {31'h0, o_xgmii_ena}, 32'h1);
            chk("run_err", {31'h0, o_underrun_err}, 32'h0);
        end
        chk("run_drain", exp_q.size(), 0);
        chk("run_src_empty", src_q.size(), 0);
        chk("run_cnt", {28'h0, o_frame_cnt}, {28'h0, 4'(exp_cnt)});
        i_xgmii_rdy = 1'b1;
        set_src(1'b0, '0, '0, 1'b0);
    endtask

    task automatic start_frame(input string nm);
        logic acc, rs;
        int g;
        set_src(1'b1, 32'h11111111, 4'hF, 1'b0);
        acc = 1'b0;
        g = 0;
        while (!acc && g < 20) begin
            g++;
            tick(acc, rs);
        end
        chk({nm, "_w0_acc"}, {31'h0, acc}, 32'h1);
        set_src(1'b1, 32'h22222222, 4'hF, 1'b0);
        tick(acc, rs);
        chk({nm, "_w1_acc"}, {31'h0, acc}, 32'h1);
        chk({nm, "_w1_data"}, o_xgmii_data, 32'h22222222);
    endtask

    initial begin
        logic acc, rs;
        tv[0]  = '{1, 32'h34333231, 4'hF, 0, 0, 32'h07070707, 4'hF, 0};
        tv[1]  = '{1, 32'h34333231, 4'hF, 0, 0, 32'h07070707, 4'hF, 0};
        tv[2]  = '{1, 32'h34333231, 4'hF, 0, 0, 32'h07070707, 4'hF, 0};
        tv[3]  = '{1, 32'h34333231, 4'hF, 0, 0, 32'h555555FB, 4'h1, 0};
        tv[4]  = '{1, 32'h34333231, 4'hF, 0, 0, 32'hD5555555, 4'h0, 0};
        tv[5]  = '{1, 32'h34333231, 4'hF, 0, 1, 32'h34333231, 4'h0, 0};
        tv[6]  = '{1, 32'h38373635, 4'hF, 0, 1, 32'h38373635, 4'h0, 0};
        tv[7]  = '{1, 32'h00000039, 4'h1, 1, 1, 32'hF4392639, 4'h0, 0};
        tv[8]  = '{0, 32'h00000000, 4'h0, 0, 0, 32'h0707FDCB, 4'hE, 1};
        tv[9]  = '{0, 32'h00000000, 4'h0, 0, 0, 32'h07070707, 4'hF, 1};
        tv[10] = '{0, 32'h00000000, 4'h0, 0, 0, 32'h07070707, 4'hF, 1};
        tv[11] = '{0, 32'h00000000, 4'h0, 0, 0, 32'h07070707, 4'hF, 1};

        rst = 1'b0;
        i_xgmii_rdy = 1'b1;
        set_src(1'b0, '0, '0, 1'b0);
        tick(acc, rs);
        tick(acc, rs);
        chk("rst_data", o_xgmii_data, 32'h07070707);
        chk("rst_ctrl", {28'h0, o_xgmii_ctrl}, 32'hF);
        chk("rst_ena", {31'h0, o_xgmii_ena}, 32'h0);
        chk("rst_err", {31'h0, o_underrun_err}, 32'h0);
        chk("rst_cnt", {28'h0, o_frame_cnt}, 32'h0);
        chk("rst_ready", {31'h0, o_s_ready}, 32'h0);
        rst = 1'b1;

        // T1: fixed vectors for "123456789"
        for (int i = 0; i < 12; i++) begin
            set_src(tv[i].v, tv[i].d, tv[i].k, tv[i].l);
            tick(acc, rs);
            chk($sformatf("t1_ready[%0d]", i), {31'h0, rs}, {31'h0, tv[i].rdy});
            chk($sformatf("t1_data[%0d]", i), o_xgmii_data, tv[i].xd);
            chk($sformatf("t1_ctrl[%0d]", i), {28'h0, o_xgmii_ctrl}, {28'h0, tv[i].xc});
            chk($sformatf("t1_cnt[%0d]", i), {28'h0, o_frame_cnt}, {28'h0, tv[i].cnt});
            chk($sformatf("t1_ena[%0d]", i), {31'h0, o_xgmii_ena}, 32'h1);
        end
        exp_cnt = 1;
        set_src(1'b0, '0, '0, 1'b0);

        // T2 + T3: 12-byte frame with keep=F tail, then back-to-back random frames
        begin
            bq_t q;
            for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
            q.push_back(8'h0A);
            q.push_back(8'h0B);
            q.push_back(8'h0C);
            add_frame(q);
        end
        repeat (4) rand_frame();
        idle_words(2);
        run(1'b0);

        // T6: reset mid-frame, then a clean frame with a fresh CRC
        start_frame("t6");
        rst = 1'b0;
        set_src(1'b0, '0, '0, 1'b0);
        tick(acc, rs);
        chk("t6_data", o_xgmii_data, 32'h07070707);
        chk("t6_ctrl", {28'h0, o_xgmii_ctrl}, 32'hF);
        chk("t6_ena", {31'h0, o_xgmii_ena}, 32'h0);
        chk("t6_cnt", {28'h0, o_frame_cnt}, 32'h0);
        chk("t6_ready", {31'h0, o_s_ready}, 32'h0);
        rst = 1'b1;
        exp_cnt = 0;
        idle_words(IPG);
        add_t1();
        rand_frame();
        idle_words(2);
        run(1'b0);

        // T4: underrun after the second data word
        start_frame("t4");
        set_src(1'b0, '0, '0, 1'b0);
        tick(acc, rs);
        chk("t4_ready_data", {31'h0, rs}, 32'h1);
        chk("t4_err_data", o_xgmii_data, 32'hFEFEFEFE);
        chk("t4_err_ctrl", {28'h0, o_xgmii_ctrl}, 32'hF);
        chk("t4_err_pulse", {31'h0, o_underrun_err}, 32'h1);
        repeat (2) begin
            tick(acc, rs);
            chk("t4_drop_ready", {31'h0, rs}, 32'h1);
            chk("t4_drop_data", o_xgmii_data, 32'h07070707);
            chk("t4_drop_err", {31'h0, o_underrun_err}, 32'h0);
        end
        set_src(1'b1, 32'h33333333, 4'hF, 1'b0);
        tick(acc, rs);
        chk("t4_disc_acc", {31'h0, acc}, 32'h1);
        chk("t4_disc_data", o_xgmii_data, 32'h07070707);
        set_src(1'b1, 32'h00004444, 4'h3, 1'b1);
        tick(acc, rs);
        chk("t4_last_acc", {31'h0, acc}, 32'h1);
        chk("t4_last_data", o_xgmii_data, 32'h07070707);
        chk("t4_cnt", {28'h0, o_frame_cnt}, {28'h0, 4'(exp_cnt)});
        set_src(1'b0, '0, '0, 1'b0);
        idle_words(IPG);
        rand_frame();
        idle_words(2);
        run(1'b0);

        // T5: T1 and random frames under random downstream backpressure (frame_cnt wraps)
        add_t1();
        repeat (20) rand_frame();
        idle_words(2);
        run(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
